// File: rtl/z_bus_drain_if.sv
// Bus-side bundle of the Z result drain: capture handshake, bus arbitration,
// the data/strobe pair driven toward the CPU bus, and completion status.
interface z_bus_drain_if #(
    parameter int DATA_WIDTH_IN = 64,
    parameter int BUS_WIDTH     = 32
);
    logic                     z_valid;
    logic [DATA_WIDTH_IN-1:0] z_data;
    logic                     z_split;
    logic                     z_ready;
    logic                     bus_req;
    logic                     bus_grant;
    logic [BUS_WIDTH-1:0]     BusMuxOut;
    logic                     ZLowout;
    logic                     ZHighout;
    logic                     done;
    logic [7:0]               xfer_count;

    // Producer/arbiter side: supplies results and grants, observes the drain.
    modport master (
        output z_valid, z_data, z_split, bus_grant,
        input  z_ready, bus_req, BusMuxOut, ZLowout, ZHighout, done, xfer_count
    );

    // Drain side: the z_bus_drain block itself.
    modport slave (
        input  z_valid, z_data, z_split, bus_grant,
        output z_ready, bus_req, BusMuxOut, ZLowout, ZHighout, done, xfer_count
    );
endinterface

// File: rtl/z_bus_drain.sv
// Captures a wide Z result and drains it onto the narrower CPU bus as one
// (LO) or two (LO then HI) granted beats, back-to-back with no idle bubble.
module z_bus_drain #(
    parameter int DATA_WIDTH_IN = 64,
    parameter int BUS_WIDTH     = 32
) (
    input  logic           clock,
    input  logic           clear_n,
    z_bus_drain_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH_IN-1:0] buf_q, buf_d;
    logic                     split_q, split_d;
    logic                     done_q, done_d;
    logic [7:0]               count_q, count_d;
    logic                     final_beat;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d       = state_q;
        buf_d         = buf_q;
        split_d       = split_q;
        done_d        = 1'b0;
        count_d       = count_q;
        final_beat    = 1'b0;
        bus.z_ready   = 1'b0;
        bus.bus_req   = 1'b0;
        bus.BusMuxOut = '0;
        bus.ZLowout   = 1'b0;
        bus.ZHighout  = 1'b0;

        case (state_q)
            IDLE: bus.z_ready = 1'b1;
            LOW: begin
                bus.bus_req   = 1'b1;
                bus.BusMuxOut = buf_q[BUS_WIDTH-1:0];
                bus.ZLowout   = bus.bus_grant;
                if (bus.bus_grant) begin
                    if (split_q) state_d = HIGH;
                    else         final_beat = 1'b1;
                end
            end
            HIGH: begin
                bus.bus_req   = 1'b1;
                bus.BusMuxOut = buf_q[DATA_WIDTH_IN-1:BUS_WIDTH];
                bus.ZHighout  = bus.bus_grant;
                final_beat    = bus.bus_grant;
            end
            default: state_d = IDLE;
        endcase

        // Final beat frees the buffer this very cycle so a waiting result loads with no bubble.
        if (final_beat) begin
            bus.z_ready = 1'b1;
            done_d      = 1'b1;
            count_d     = count_q + 8'd1;
            state_d     = IDLE;
        end

        if (bus.z_valid && bus.z_ready) begin
            buf_d   = bus.z_data;
            split_d = bus.z_split;
            state_d = LOW;
        end
    end

    // NOTE: the result buffer is reset too, so BusMuxOut can never leak stale data after an abort.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            split_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q <= state_d;
            buf_q   <= buf_d;
            split_q <= split_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign bus.done       = done_q;
    assign bus.xfer_count = count_q;
endmodule

// File: tb/tb_z_bus_drain.sv
// Randomized and directed bench for z_bus_drain against a queue-of-beats
// reference model: each captured result becomes one or two pending bus beats.
module tb_z_bus_drain;
    localparam int DW = 64;
    localparam int BW = 32;

    typedef struct {
        logic [BW-1:0] data;
        bit            high;
    } beat_t;

    logic clock;
    logic clear_n;

    z_bus_drain_if #(.DATA_WIDTH_IN(DW), .BUS_WIDTH(BW)) bus ();

    z_bus_drain #(.DATA_WIDTH_IN(DW), .BUS_WIDTH(BW)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending beats of the result in flight, plus registered status.
    beat_t      pend[$];
    bit         exp_done;
    logic [7:0] exp_count;

    // Observations of the most recent step, for directed constant checks.
    logic [BW-1:0] obs_mux;
    logic          obs_lo, obs_hi, obs_req, obs_ready, obs_done;
    logic [7:0]    obs_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_done  = 1'b0;
        exp_count = 8'd0;
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, advance both.
    task automatic step(input bit v, input logic [DW-1:0] data, input bit split, input bit grant);
        bit            empty, ready;
        logic [BW-1:0] mux;
        beat_t         b;
        @(negedge clock);
        bus.z_valid   = v;
        bus.z_data    = data;
        bus.z_split   = split;
        bus.bus_grant = grant;
        #1;
        empty = (pend.size() == 0);
        ready = empty || (grant && pend.size() == 1);
        mux   = empty ? '0 : pend[0].data;
        obs_mux   = bus.BusMuxOut;
        obs_lo    = bus.ZLowout;
        obs_hi    = bus.ZHighout;
        obs_req   = bus.bus_req;
        obs_ready = bus.z_ready;
        obs_done  = bus.done;
        obs_count = bus.xfer_count;
        check("z_ready",    obs_ready, ready);
        check("bus_req",    obs_req,   !empty);
        check("BusMuxOut",  obs_mux,   mux);
        check("ZLowout",    obs_lo,    !empty && grant && !pend[0].high);
        check("ZHighout",   obs_hi,    !empty && grant && pend[0].high);
        check("done",       obs_done,  exp_done);
        check("xfer_count", obs_count, exp_count);
        @(posedge clock);
        exp_done = 1'b0;
        if (!empty && grant) begin
            void'(pend.pop_front());
            if (pend.size() == 0) begin
                exp_done  = 1'b1;
                exp_count = exp_count + 8'd1;
            end
        end
        if (v && ready) begin
            b.data = data[BW-1:0]; b.high = 1'b0; pend.push_back(b);
            if (split) begin
                b.data = data[DW-1:BW]; b.high = 1'b1; pend.push_back(b);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.z_ready,    1'b1);
        check({tag, "_req"},   bus.bus_req,    1'b0);
        check({tag, "_mux"},   bus.BusMuxOut,  '0);
        check({tag, "_lo"},    bus.ZLowout,    1'b0);
        check({tag, "_hi"},    bus.ZHighout,   1'b0);
        check({tag, "_done"},  bus.done,       1'b0);
        check({tag, "_count"}, bus.xfer_count, 8'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        bus.z_valid = 1'b0; bus.bus_grant = 1'b0;
        clear_n = 1'b0;
        #1;
        check_reset_outputs("rst_pulse");
        model_reset();
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    logic [DW-1:0] rnd;

    initial begin
        clear_n       = 1'b1;
        bus.z_valid   = 1'b0;
        bus.z_data    = '0;
        bus.z_split   = 1'b0;
        bus.bus_grant = 1'b0;
        model_reset();
        #1 clear_n = 1'b0;
        #1 check_reset_outputs("por");
        @(negedge clock);
        clear_n = 1'b1;

        // Split drain with grant held.
        step(1'b1, 64'h0000_0001_8000_0000, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("split_lo_data", obs_mux, 32'h8000_0000);
        check("split_lo_strobe", obs_lo, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("split_hi_data", obs_mux, 32'h0000_0001);
        check("split_hi_strobe", obs_hi, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("split_done", obs_done, 1'b1);
        check("split_count", obs_count, 8'd1);

        // Single beat.
        step(1'b1, 64'hFFFF_FFFF_0000_002A, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("single_data", obs_mux, 32'h0000_002A);
        check("single_lo", obs_lo, 1'b1);
        check("single_no_hi", obs_hi, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("single_done", obs_done, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("single_done_once", obs_done, 1'b0);

        // Grant stall: 5 ungranted cycles in LOW, 3 in HIGH.
        rnd = {$urandom, $urandom};
        step(1'b1, rnd, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        check("stall_hi_data", obs_mux, rnd[DW-1:BW]);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Back-to-back single-beat results.
        step(1'b1, 64'h1111_1111_AAAA_0001, 1'b0, 1'b1);
        step(1'b1, 64'h2222_2222_BBBB_0002, 1'b0, 1'b1);
        check("b2b_first", obs_mux, 32'hAAAA_0001);
        step(1'b0, '0, 1'b0, 1'b1);
        check("b2b_second", obs_mux, 32'hBBBB_0002);
        check("b2b_no_bubble", obs_lo, 1'b1);
        check("b2b_done1", obs_done, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("b2b_done2", obs_done, 1'b1);

        // Mid-transfer reset while in HIGH.
        step(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        @(negedge clock);
        bus.bus_grant = 1'b1;
        #1 check("pre_rst_hi", bus.ZHighout, 1'b1);
        #1 clear_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clock);
        #1 check("mid_rst_no_done", bus.done, 1'b0);
        @(negedge clock);
        clear_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 1) == 1, {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Counter wrap after 256 results.
        pulse_reset();
        for (int i = 0; i < 256; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("wrap_count", obs_count, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
